// File: rtl/mems_spi_reader.sv
// SPI mode-3 master for MEMS register access: single-byte writes and burst reads.
// SCLK timing is derived from rising edges of sclk_ref, which is sampled as data in the clk domain.
module mems_spi_reader #(
  parameter int MAX_BYTES      = 8,
  parameter int CNT_W          = 4,
  parameter int CS_SETUP_TICKS = 1,
  parameter int CS_HOLD_TICKS  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk_ref,
  input  logic             start,
  input  logic             wr,
  input  logic [5:0]       reg_addr,
  input  logic [7:0]       wr_data,
  input  logic [CNT_W-1:0] num_bytes,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             spi_cs_n,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int TICK_MAX = (CS_SETUP_TICKS > CS_HOLD_TICKS) ? CS_SETUP_TICKS : CS_HOLD_TICKS;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

  state_t             state;
  logic               sync_p0, sync_p1, dly_p2;
  logic               tick;
  logic [TICK_W-1:0]  tick_cnt;
  logic [2:0]         bit_cnt;
  logic [CNT_W-1:0]   byte_cnt;
  logic [CNT_W-1:0]   len_q;
  logic               wr_q;
  logic               rd_pend;
  logic [7:0]         wr_data_q;
  logic [7:0]         tx_sh;
  logic [7:0]         rx_sh;

  function automatic logic [CNT_W-1:0] eff_len(input logic w, input logic [CNT_W-1:0] n);
    logic [CNT_W-1:0] r;
    if (w || n == '0)
      r = CNT_W'(1);
    else if (n > CNT_W'(MAX_BYTES))
      r = CNT_W'(MAX_BYTES);
    else
      r = n;
    return r;
  endfunction

  // MS (auto-increment) is only set for reads longer than one byte
  function automatic logic [7:0] cmd_byte(input logic w, input logic [CNT_W-1:0] len,
                                          input logic [5:0] a);
    return {~w, ~w & (len > CNT_W'(1)), a};
  endfunction

  // Stage p0/p1: synchronizer, p2: edge-detect delay
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      dly_p2  <= 1'b0;
    end else begin
      sync_p0 <= sclk_ref;
      sync_p1 <= sync_p0;
      dly_p2  <= sync_p1;
    end
  end

  assign tick = sync_p1 & ~dly_p2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      len_q    <= '0;
      wr_q     <= 1'b0;
      rd_pend  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b1;
      spi_mosi <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_pend  <= 1'b0;
      if (rd_pend) begin
        rd_data  <= rx_sh;
        rd_valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            wr_q     <= wr;
            len_q    <= eff_len(wr, num_bytes);
            tick_cnt <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            spi_cs_n <= 1'b0;
            spi_sclk <= 1'b1;
            busy     <= 1'b1;
            state    <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (tick) begin
            if (tick_cnt == TICK_W'(CS_SETUP_TICKS - 1)) begin
              tick_cnt <= '0;
              state    <= SHIFT;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        SHIFT: begin
          if (tick) begin
            if (spi_sclk) begin
              spi_sclk <= 1'b0;
              spi_mosi <= tx_sh[7];
            end else begin
              spi_sclk <= 1'b1;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) begin
                byte_cnt <= byte_cnt + 1'b1;
                // byte 0 is the command; its MISO content is discarded
                if (byte_cnt != '0 && !wr_q)
                  rd_pend <= 1'b1;
                if (byte_cnt == len_q)
                  state <= CS_HOLD;
              end
            end
          end
        end
        CS_HOLD: begin
          if (tick) begin
            if (tick_cnt == TICK_W'(CS_HOLD_TICKS - 1)) begin
              tick_cnt <= '0;
              spi_cs_n <= 1'b1;
              spi_mosi <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift datapath: loaded on start, advanced by SCLK edges while in SHIFT
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      tx_sh     <= cmd_byte(wr, eff_len(wr, num_bytes), reg_addr);
      wr_data_q <= wr_data;
    end else if (state == SHIFT && tick) begin
      if (spi_sclk) begin
        tx_sh <= {tx_sh[6:0], 1'b0};
      end else begin
        rx_sh <= {rx_sh[6:0], spi_miso};
        if (bit_cnt == 3'd7)
          tx_sh <= wr_q ? wr_data_q : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_mems_spi_reader.sv
// Directed bench for mems_spi_reader: mode-3 slave model, table of transactions, and corner sequences.
module tb_mems_spi_reader;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             sclk_ref = 1'b0;
  logic             start = 1'b0;
  logic             wr = 1'b0;
  logic [5:0]       reg_addr = '0;
  logic [7:0]       wr_data = '0;
  logic [CNT_W-1:0] num_bytes = '0;
  logic             spi_miso = 1'b0;
  logic             busy, done, rd_valid, spi_cs_n, spi_sclk, spi_mosi;
  logic [7:0]       rd_data;

  mems_spi_reader #(.MAX_BYTES(8), .CNT_W(CNT_W), .CS_SETUP_TICKS(1), .CS_HOLD_TICKS(1)) dut (
    .clk(clk), .reset(reset), .sclk_ref(sclk_ref), .start(start), .wr(wr),
    .reg_addr(reg_addr), .wr_data(wr_data), .num_bytes(num_bytes),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  // divider N=8: sclk_ref toggles every 8 clk, one tick per 16 clk
  int div_cnt = 0;
  always @(posedge clk) begin
    if (div_cnt == 7) begin
      div_cnt <= 0;
      sclk_ref <= ~sclk_ref;
    end else begin
      div_cnt <= div_cnt + 1;
    end
  end

  // mode-3 slave: MISO changes on SCLK fall, MOSI captured on SCLK rise
  logic [63:0] sl_tx = '0;
  int          rise_total = 0;
  int          rise_base = 0;
  logic        mosi_bits [1024];

  always @(negedge spi_cs_n) rise_base = rise_total;

  always @(posedge spi_sclk) begin
    if (spi_cs_n === 1'b0) begin
      mosi_bits[rise_total] = spi_mosi;
      rise_total++;
    end
  end

  always @(negedge spi_sclk) begin
    int k;
    if (spi_cs_n === 1'b0) begin
      k = rise_total - rise_base;
      if (k >= 8 && k < 72) spi_miso = sl_tx[63 - (k - 8)];
      else spi_miso = 1'b0;
    end
  end

  int          cyc = 0, rd_total = 0, done_total = 0, cs_fall_total = 0, idle_low_err = 0;
  logic [7:0]  rd_vals [64];
  int          t_cs_fall = 0, t_first_fall = 0, t_last_rise = 0, t_cs_rise = 0;
  logic        first_seen = 1'b1, prev_cs = 1'b1, prev_sclk = 1'b1;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rd_valid === 1'b1) begin
      rd_vals[rd_total] = rd_data;
      rd_total++;
    end
    if (done === 1'b1) done_total++;
    if (prev_cs && spi_cs_n === 1'b0) begin
      t_cs_fall = cyc;
      first_seen = 1'b0;
      cs_fall_total++;
    end
    if (spi_cs_n === 1'b0 && prev_sclk && spi_sclk === 1'b0 && !first_seen) begin
      t_first_fall = cyc;
      first_seen = 1'b1;
    end
    if (!prev_sclk && spi_sclk === 1'b1) t_last_rise = cyc;
    if (!prev_cs && spi_cs_n === 1'b1) t_cs_rise = cyc;
    if (spi_cs_n === 1'b1 && spi_sclk !== 1'b1) idle_low_err++;
    prev_cs = (spi_cs_n !== 1'b0);
    prev_sclk = (spi_sclk !== 1'b0);
  end

  int n_cmp = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int min);
    n_cmp++;
    if (act < min) begin
      n_err++;
      $display("FAIL %s: got %0d expected >= %0d", name, act, min);
    end
  endtask

  function automatic logic [7:0] mbyte(input int base, input int b);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[7-j] = mosi_bits[base + 8*b + j];
    return r;
  endfunction

  typedef struct {
    logic             wr;
    logic [5:0]       addr;
    logic [7:0]       wdata;
    logic [CNT_W-1:0] nbytes;
    logic [63:0]      miso;
    logic [7:0]       exp_cmd;
    int               exp_len;
  } vec_t;

  vec_t vecs [7];

  task automatic wait_done(input int dn0, input int limit);
    for (int i = 0; i < limit && done_total == dn0; i++) @(negedge clk);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int rd0, dn0, cs0, mb;
    logic [63:0] m;
    m = v.miso;
    @(negedge clk);
    wr = v.wr; reg_addr = v.addr; wr_data = v.wdata; num_bytes = v.nbytes; sl_tx = v.miso;
    rd0 = rd_total; dn0 = done_total; cs0 = cs_fall_total; mb = rise_total;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reg_addr = ~v.addr; wr_data = ~v.wdata; num_bytes = 4'd3; wr = ~v.wr;
    wait_done(dn0, 6000);
    repeat (40) @(negedge clk);
    check({tag, "_done"}, done_total - dn0, 1);
    check({tag, "_csfalls"}, cs_fall_total - cs0, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cs_n"}, spi_cs_n, 1);
    check({tag, "_sclk"}, spi_sclk, 1);
    check({tag, "_mosi_idle"}, spi_mosi, 0);
    check({tag, "_sclk_cycles"}, rise_total - mb, 8 * (1 + v.exp_len));
    check({tag, "_cmd"}, mbyte(mb, 0), v.exp_cmd);
    for (int b = 1; b <= v.exp_len; b++)
      check($sformatf("%s_mosi_b%0d", tag, b), mbyte(mb, b), v.wr ? v.wdata : 8'h00);
    check({tag, "_rdcount"}, rd_total - rd0, v.wr ? 0 : v.exp_len);
    if (!v.wr) begin
      for (int b = 0; b < v.exp_len; b++)
        check($sformatf("%s_rd_b%0d", tag, b), rd_vals[rd0 + b], m[63 - 8*b -: 8]);
      check({tag, "_rd_hold"}, rd_data, m[63 - 8*(v.exp_len - 1) -: 8]);
    end
    check_ge({tag, "_cs_setup"}, t_first_fall - t_cs_fall, 16);
    check_ge({tag, "_cs_hold"}, t_cs_rise - t_last_rise, 16);
  endtask

  initial begin
    int rd0, dn0, cs0, mb;
    vecs[0] = '{1'b0, 6'h0F, 8'h00, 4'd1,  64'h3300_0000_0000_0000, 8'h8F, 1};
    vecs[1] = '{1'b0, 6'h28, 8'h00, 4'd6,  64'h0102_0304_0506_0000, 8'hE8, 6};
    vecs[2] = '{1'b1, 6'h20, 8'h57, 4'd1,  64'h0,                   8'h20, 1};
    vecs[3] = '{1'b0, 6'h0F, 8'h00, 4'd0,  64'hA500_0000_0000_0000, 8'h8F, 1};
    vecs[4] = '{1'b0, 6'h28, 8'h00, 4'd12, 64'h1122_3344_5566_7788, 8'hE8, 8};
    vecs[5] = '{1'b1, 6'h3F, 8'hC3, 4'd5,  64'hFFFF_FFFF_FFFF_FFFF, 8'h3F, 1};
    vecs[6] = '{1'b0, 6'h01, 8'h00, 4'd2,  64'hFF00_0000_0000_0000, 8'hC1, 2};

    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sclk", spi_sclk, 1);
    check("rst_mosi", spi_mosi, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // start pulsed mid-transfer must be ignored
    @(negedge clk);
    wr = 1'b0; reg_addr = 6'h0F; num_bytes = 4'd1; sl_tx = 64'h5A00_0000_0000_0000;
    rd0 = rd_total; dn0 = done_total; cs0 = cs_fall_total;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    check("mid_busy", busy, 1);
    reg_addr = 6'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(dn0, 6000);
    repeat (300) @(negedge clk);
    check("mid_done", done_total - dn0, 1);
    check("mid_csfalls", cs_fall_total - cs0, 1);
    check("mid_rdcount", rd_total - rd0, 1);
    check("mid_rd", rd_vals[rd0], 8'h5A);

    // asynchronous reset after 10 SCLK rising edges of a burst
    @(negedge clk);
    wr = 1'b0; reg_addr = 6'h28; num_bytes = 4'd6; sl_tx = 64'h0102_0304_0506_0000;
    rd0 = rd_total; dn0 = done_total; mb = rise_total;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000 && (rise_total - mb) < 10; i++) @(negedge clk);
    check("rst_mid_rises", rise_total - mb, 10);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_cs_n", spi_cs_n, 1);
    check("rst_mid_sclk", spi_sclk, 1);
    check("rst_mid_mosi", spi_mosi, 0);
    check("rst_mid_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    check("rst_mid_nodone", done_total - dn0, 0);
    check("rst_mid_nord", rd_total - rd0, 0);
    run_txn(vecs[0], "post_rst");

    // start held high: back-to-back transactions
    @(negedge clk);
    wr = 1'b0; reg_addr = 6'h0F; num_bytes = 4'd1; sl_tx = 64'h3300_0000_0000_0000;
    rd0 = rd_total; dn0 = done_total; cs0 = cs_fall_total;
    start = 1'b1;
    for (int i = 0; i < 8000 && (done_total - dn0) < 2; i++) @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    check("b2b_done", done_total - dn0, 2);
    check("b2b_csfalls", cs_fall_total - cs0, 2);
    check("b2b_rdcount", rd_total - rd0, 2);
    check("b2b_busy", busy, 0);

    check("sclk_high_when_cs_high", idle_low_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
